// File: rtl/gesture_decision_filter_if.sv
// Result/event bundle between the classifier, the gesture decision filter and the reporting logic.
// master drives classifier results and consumes gesture events; slave is the filter.
interface gesture_decision_filter_if #(
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned ACC_BITS    = 24
);
  logic                            result_valid;
  logic [1:0]                      best_class;
  logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat;
  logic [ACC_BITS-1:0]             margin_thresh;
  logic                            gesture_valid;
  logic [1:0]                      gesture_class;
  logic [ACC_BITS-1:0]             gesture_margin;
  logic [3:0]                      streak_count;
  logic                            cooldown_active;

  modport master (
    output result_valid,
    output best_class,
    output scores_flat,
    output margin_thresh,
    input  gesture_valid,
    input  gesture_class,
    input  gesture_margin,
    input  streak_count,
    input  cooldown_active
  );

  modport slave (
    input  result_valid,
    input  best_class,
    input  scores_flat,
    input  margin_thresh,
    output gesture_valid,
    output gesture_class,
    output gesture_margin,
    output streak_count,
    output cooldown_active
  );
endinterface

// File: rtl/gesture_decision_filter.sv
// Confirms classifier gestures after CONFIRM_COUNT agreeing results whose margin clears a threshold.
// Define GESTURE_FILTER_COOLDOWN_EN to add a post-event cooldown of COOLDOWN_CYCLES clocks.
module gesture_decision_filter #(
  parameter int unsigned NUM_CLASSES     = 4,
  parameter int unsigned ACC_BITS        = 24,
  parameter int unsigned CONFIRM_COUNT   = 3,
  parameter int unsigned COOLDOWN_CYCLES = 50000
) (
  input logic                      clk,
  input logic                      rst_n,
  gesture_decision_filter_if.slave bus
);

  localparam int unsigned ScoreW     = NUM_CLASSES * ACC_BITS;
  localparam logic [3:0]  ConfirmCnt = 4'(CONFIRM_COUNT);

  logic armed;

  // Stage 1: capture the classifier result.
  logic              s1_valid_q;
  logic [1:0]        s1_class_q;
  logic [ScoreW-1:0] s1_scores_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_class_q  <= '0;
      s1_scores_q <= '0;
    end else begin
      s1_valid_q <= bus.result_valid;
      if (bus.result_valid) begin
        s1_class_q  <= bus.best_class;
        s1_scores_q <= bus.scores_flat;
      end
    end
  end

  // Stage 2: margin of the reported winner over the best of the rest.
  logic signed [ACC_BITS-1:0] score [NUM_CLASSES];
  logic signed [ACC_BITS-1:0] top;
  logic signed [ACC_BITS-1:0] second;
  logic                       second_found;
  logic signed [ACC_BITS:0]   diff;
  logic [ACC_BITS-1:0]        margin;
  logic                       qualified;

  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      score[k] = s1_scores_q[k*ACC_BITS +: ACC_BITS];
    end
  end

  always_comb begin
    top          = score[s1_class_q];
    second       = '0;
    second_found = 1'b0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (2'(k) != s1_class_q && (!second_found || score[k] > second)) begin
        second       = score[k];
        second_found = 1'b1;
      end
    end
  end

  // One extra bit holds the full difference, so it never exceeds 2^ACC_BITS-1; only
  // the negative side (reported class not actually the max) needs clamping.
  always_comb begin
    diff      = {top[ACC_BITS-1], top} - {second[ACC_BITS-1], second};
    margin    = diff[ACC_BITS] ? '0 : diff[ACC_BITS-1:0];
    qualified = (margin >= bus.margin_thresh);
  end

  logic                s2_valid_q;
  logic [1:0]          s2_class_q;
  logic [ACC_BITS-1:0] s2_margin_q;
  logic                s2_qual_q;

  // Results whose stage 2 lands while cooling down (including the exit edge) are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_class_q  <= '0;
      s2_margin_q <= '0;
      s2_qual_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q & armed;
      if (s1_valid_q) begin
        s2_class_q  <= s1_class_q;
        s2_margin_q <= margin;
        s2_qual_q   <= qualified;
      end
    end
  end

  // Streak tracking and confirmation.
  logic [3:0]          streak_q, streak_d, streak_inc;
  logic [1:0]          streak_class_q, streak_class_d;
  logic                confirm;
  logic                gesture_valid_q;
  logic [1:0]          gesture_class_q;
  logic [ACC_BITS-1:0] gesture_margin_q;

  always_comb begin
    streak_d       = streak_q;
    streak_class_d = streak_class_q;
    streak_inc     = streak_q;
    confirm        = 1'b0;
    if (s2_valid_q && armed) begin
      if (!s2_qual_q) begin
        streak_d = '0;
      end else begin
        if (streak_q != 4'd0 && s2_class_q == streak_class_q) begin
          streak_inc = streak_q + 4'd1;
        end else begin
          streak_inc     = 4'd1;
          streak_class_d = s2_class_q;
        end
        if (streak_inc == ConfirmCnt) begin
          confirm  = 1'b1;
          streak_d = '0;
        end else begin
          streak_d = streak_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q         <= '0;
      streak_class_q   <= '0;
      gesture_valid_q  <= 1'b0;
      gesture_class_q  <= '0;
      gesture_margin_q <= '0;
    end else begin
      streak_q        <= streak_d;
      streak_class_q  <= streak_class_d;
      gesture_valid_q <= confirm;
      if (confirm) begin
        gesture_class_q  <= s2_class_q;
        gesture_margin_q <= s2_margin_q;
      end
    end
  end

  assign bus.gesture_valid  = gesture_valid_q;
  assign bus.gesture_class  = gesture_class_q;
  assign bus.gesture_margin = gesture_margin_q;
  assign bus.streak_count   = streak_q;

`ifdef GESTURE_FILTER_COOLDOWN_EN
  localparam logic StArmed    = 1'b0;
  localparam logic StCooldown = 1'b1;
  localparam bit   CooldownOn = (COOLDOWN_CYCLES != 0);

  logic        state_q, state_d;
  logic [15:0] cool_cnt_q, cool_cnt_d;

  // Counter loaded on the event edge; exit happens on the edge where it would hit 0.
  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    unique case (state_q)
      StArmed: begin
        if (confirm && CooldownOn) begin
          state_d    = StCooldown;
          cool_cnt_d = 16'(COOLDOWN_CYCLES);
        end
      end
      StCooldown: begin
        if (cool_cnt_q <= 16'd1) begin
          state_d    = StArmed;
          cool_cnt_d = '0;
        end else begin
          cool_cnt_d = cool_cnt_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StArmed;
      cool_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
    end
  end

  assign armed               = (state_q == StArmed);
  assign bus.cooldown_active = (state_q == StCooldown);
`else
  logic unused_cooldown_cfg;

  assign armed               = 1'b1;
  assign bus.cooldown_active = 1'b0;
  assign unused_cooldown_cfg = ^32'(COOLDOWN_CYCLES);
`endif

endmodule

// File: tb/tb_gesture_decision_filter.sv
// Directed bench for gesture_decision_filter: streaks, margin rejection, saturation, reset,
// and (when GESTURE_FILTER_COOLDOWN_EN is defined) cooldown behaviour.
module tb_gesture_decision_filter;

  localparam int unsigned AccBits    = 24;
  localparam int unsigned CoolCycles = 20;
`ifdef GESTURE_FILTER_COOLDOWN_EN
  localparam int Settle  = CoolCycles + 2;
  localparam bit CoolExp = 1'b1;
`else
  localparam int Settle  = 0;
  localparam bit CoolExp = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  gesture_decision_filter_if #(.NUM_CLASSES(4), .ACC_BITS(AccBits)) bus ();

  gesture_decision_filter #(
    .NUM_CLASSES    (4),
    .ACC_BITS       (AccBits),
    .CONFIRM_COUNT  (3),
    .COOLDOWN_CYCLES(CoolCycles)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ev_cnt      = 0;
  int cd_cnt      = 0;
  int ev_base;

  always @(negedge clk) begin
    if (bus.gesture_valid === 1'b1) ev_cnt++;
    if (bus.cooldown_active === 1'b1) cd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [1:0] cls, input logic [23:0] s0, input logic [23:0] s1,
                        input logic [23:0] s2, input logic [23:0] s3);
    bus.result_valid = 1'b1;
    bus.best_class   = cls;
    bus.scores_flat  = {s3, s2, s1, s0};
    @(negedge clk);
    bus.result_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.result_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One result, then wait until its streak update is visible.
  task automatic apply(input logic [1:0] cls, input logic [23:0] s0, input logic [23:0] s1,
                       input logic [23:0] s2, input logic [23:0] s3);
    strobe(cls, s0, s1, s2, s3);
    idle(2);
  endtask

  initial begin
    bus.result_valid  = 1'b0;
    bus.best_class    = '0;
    bus.scores_flat   = '0;
    bus.margin_thresh = '0;
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(bus.gesture_valid), 0);
    check("rst_class", 32'(bus.gesture_class), 0);
    check("rst_margin", 32'(bus.gesture_margin), 0);
    check("rst_streak", 32'(bus.streak_count), 0);
    check("rst_cool", 32'(bus.cooldown_active), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Streak confirm, margin 80
    bus.margin_thresh = 24'd10;
    ev_base = ev_cnt;
    apply(2, 24'd0, 24'd5, 24'd100, 24'd20);
    check("cfm_streak1", 32'(bus.streak_count), 1);
    apply(2, 24'd0, 24'd5, 24'd100, 24'd20);
    check("cfm_streak2", 32'(bus.streak_count), 2);
    check("cfm_novalid", 32'(bus.gesture_valid), 0);
    cd_cnt = 0;
    strobe(2, 24'd0, 24'd5, 24'd100, 24'd20);
    idle(1);
    check("cfm_early", 32'(bus.gesture_valid), 0);
    idle(1);
    check("cfm_valid", 32'(bus.gesture_valid), 1);
    check("cfm_class", 32'(bus.gesture_class), 2);
    check("cfm_margin", 32'(bus.gesture_margin), 80);
    check("cfm_streak0", 32'(bus.streak_count), 0);
    check("cfm_cool", 32'(bus.cooldown_active), 32'(CoolExp));
    idle(1);
    check("cfm_pulse", 32'(bus.gesture_valid), 0);
    check("cfm_events", 32'(ev_cnt - ev_base), 1);

`ifdef GESTURE_FILTER_COOLDOWN_EN
    // Qualifying results during cooldown are discarded
    repeat (3) begin
      apply(1, 24'd0, 24'd100, 24'd0, 24'd0);
      check("cd_streak", 32'(bus.streak_count), 0);
    end
    idle(15);
    check("cd_events", 32'(ev_cnt - ev_base), 1);
    check("cd_cycles", 32'(cd_cnt), CoolCycles);
    check("cd_exit", 32'(bus.cooldown_active), 0);
    apply(1, 24'd0, 24'd100, 24'd0, 24'd0);
    check("cd_after1", 32'(bus.streak_count), 1);
    apply(1, 24'd0, 24'd100, 24'd0, 24'd0);
    apply(1, 24'd0, 24'd100, 24'd0, 24'd0);
    check("cd_after_ev", 32'(bus.gesture_valid), 1);
    check("cd_after_cls", 32'(bus.gesture_class), 1);
    check("cd_after_mg", 32'(bus.gesture_margin), 100);
    idle(Settle);
`endif

    // Threshold 0 accepts a tie; a rejected result clears the streak
    bus.margin_thresh = 24'd0;
    apply(0, 24'd50, 24'd50, 24'd0, 24'd0);
    check("thr0_tie", 32'(bus.streak_count), 1);
    bus.margin_thresh = 24'd100;
    ev_base = ev_cnt;
    apply(1, 24'd10, 24'd90, 24'd0, 24'd0);
    check("rej_margin", 32'(bus.streak_count), 0);
    bus.margin_thresh = 24'd1;
    apply(0, 24'd50, 24'd50, 24'd0, 24'd0);
    check("rej_tie", 32'(bus.streak_count), 0);
    idle(2);
    check("rej_events", 32'(ev_cnt - ev_base), 0);

    // Class switch 0,0,3,3,3
    bus.margin_thresh = 24'd10;
    apply(0, 24'd100, 24'd0, 24'd0, 24'd0);
    check("sw_s1", 32'(bus.streak_count), 1);
    apply(0, 24'd100, 24'd0, 24'd0, 24'd0);
    check("sw_s2", 32'(bus.streak_count), 2);
    apply(3, 24'd0, 24'd0, -24'sd5, 24'd60);
    check("sw_s3", 32'(bus.streak_count), 1);
    apply(3, 24'd0, 24'd0, -24'sd5, 24'd60);
    check("sw_s4", 32'(bus.streak_count), 2);
    apply(3, 24'd0, 24'd0, -24'sd5, 24'd60);
    check("sw_valid", 32'(bus.gesture_valid), 1);
    check("sw_class", 32'(bus.gesture_class), 3);
    check("sw_margin", 32'(bus.gesture_margin), 60);
    idle(Settle + 1);

    // Reported class below a rival: negative margin clamps to 0
    bus.margin_thresh = 24'd0;
    repeat (3) apply(1, 24'd50, 24'd10, 24'd0, 24'd0);
    check("clamp_valid", 32'(bus.gesture_valid), 1);
    check("clamp_class", 32'(bus.gesture_class), 1);
    check("clamp_margin", 32'(bus.gesture_margin), 0);
    idle(Settle + 1);

    // Back-to-back strobes with saturating margin
    bus.margin_thresh = 24'd10;
    repeat (3) strobe(0, 24'h7FFFFF, 24'h800000, 24'h800000, 24'h800000);
    idle(1);
    check("b2b_early", 32'(bus.gesture_valid), 0);
    idle(1);
    check("b2b_valid", 32'(bus.gesture_valid), 1);
    check("b2b_class", 32'(bus.gesture_class), 0);
    check("sat_margin", 32'(bus.gesture_margin), 32'h00FF_FFFF);
    idle(Settle + 1);

    // Async reset mid-streak
    apply(2, 24'd0, 24'd5, 24'd100, 24'd20);
    apply(2, 24'd0, 24'd5, 24'd100, 24'd20);
    check("ar_pre", 32'(bus.streak_count), 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_streak", 32'(bus.streak_count), 0);
    check("ar_margin", 32'(bus.gesture_margin), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ev_base = ev_cnt;
    apply(2, 24'd0, 24'd5, 24'd100, 24'd20);
    check("ar_post", 32'(bus.streak_count), 1);
    idle(3);
    check("ar_events", 32'(ev_cnt - ev_base), 0);

`ifdef GESTURE_FILTER_COOLDOWN_EN
    // Async reset mid-cooldown
    apply(2, 24'd0, 24'd5, 24'd100, 24'd20);
    apply(2, 24'd0, 24'd5, 24'd100, 24'd20);
    idle(3);
    check("arc_cool_on", 32'(bus.cooldown_active), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arc_cool_off", 32'(bus.cooldown_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
